fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning entry count; it must be a power of two and at least 2.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: the fetch side offers IN_PC/IN_INSTR.
REQ-007 The block SHALL have port IN_READY, output, 1 bit: the queue accepts a push this cycle.
REQ-008 The block SHALL have port IN_PC, input, AW bits: PC of the offered instruction.
REQ-009 The block SHALL have port IN_INSTR, input, DW bits: the offered instruction word.
REQ-010 The block SHALL have port OUT_VALID, output, 1 bit: the head entry is presented to decode.
REQ-011 The block SHALL have port OUT_READY, input, 1 bit: decode consumes the head this cycle.
REQ-012 The block SHALL have port OUT_PC, output, AW bits: PC of the head entry.
REQ-013 The block SHALL have port OUT_INSTR, output, DW bits: instruction of the head entry.
REQ-014 The block SHALL have port FLUSH, input, 1 bit: discard all entries (branch redirect).
REQ-015 The block SHALL have port COUNT, output, log2(DEPTH)+1 bits: current occupancy.
REQ-016 The block SHALL have ports FULL and EMPTY, outputs, 1 bit each: COUNT==DEPTH and COUNT==0 respectively.

Function
REQ-017 A push SHALL occur exactly when IN_VALID and IN_READY are both 1 at a rising CLK edge; the entry {IN_PC, IN_INSTR} is written at the write pointer.
REQ-018 A pop SHALL occur exactly when OUT_VALID and OUT_READY are both 1 at a rising CLK edge; the read pointer advances.
REQ-019 IN_READY SHALL equal !FULL, decoded from registered state only, with no combinational path from OUT_READY or IN_VALID.
REQ-020 OUT_VALID SHALL equal !EMPTY; OUT_PC/OUT_INSTR SHALL show the head entry combinationally from storage (first-word fall-through).
REQ-021 Latency SHALL be 1 cycle: an entry pushed at edge N is visible with OUT_VALID=1 after edge N; there is no same-cycle bypass while empty.
REQ-022 OUT_PC/OUT_INSTR SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 When a push and a pop occur in the same cycle, COUNT SHALL be unchanged and both pointers SHALL advance.
REQ-024 Pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH or underflow below 0.
REQ-025 FLUSH=1 at an edge SHALL set both pointers and COUNT to 0; any push or pop in that cycle SHALL be discarded, so FLUSH has priority over both.
REQ-026 After a flush, EMPTY SHALL be 1 and IN_READY SHALL be 1 in the next cycle.
REQ-027 Entries SHALL leave in push order; no entry is ever duplicated or dropped except by FLUSH or reset.
REQ-028 OUT_PC/OUT_INSTR SHALL be ignored by consumers while OUT_VALID=0; benches check data only while OUT_VALID=1.

Reset
REQ-029 RST_N=0 SHALL immediately, without waiting for CLK, clear pointers, COUNT and all storage to 0.
REQ-030 During and after reset the block SHALL drive OUT_VALID=0, IN_READY=1, EMPTY=1, FULL=0, COUNT=0, OUT_PC=0 and OUT_INSTR=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and the first push after RST_N rises SHALL be handled normally.

Verification (DEPTH=4)
REQ-032 Push PC 0..3, instructions 0xA0..0xA3, OUT_READY=0 -> COUNT=4, FULL=1, IN_READY=0; a fifth offer of PC 4 is not accepted.
REQ-033 From full, set OUT_READY=1 for 4 cycles -> the queue delivers PC 0,1,2,3 in order, then EMPTY=1 and OUT_VALID=0.
REQ-034 Hold IN_VALID=1 and OUT_READY=1 continuously with PC incrementing from 0 -> after the first cycle one entry leaves per cycle, COUNT holds 1, and the pointers wrap past 3 with order preserved for 10+ entries.
REQ-035 Hold 3 entries, then assert FLUSH together with a push of PC 9 and OUT_READY=1 -> next cycle COUNT=0 and EMPTY=1, and PC 9 never appears at the output.
REQ-036 Hold 2 entries, drop RST_N asynchronously between edges -> OUT_VALID=0 and COUNT=0 before the next edge; after release, push PC 5 -> OUT_PC=5 one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a first-word fall-through FIFO of {PC, instruction} pairs
// between fetch and decode, with a flush for branch redirects.
module fetch_queue #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [AW-1:0]            IN_PC,
  input  logic [DW-1:0]            IN_INSTR,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [AW-1:0]            OUT_PC,
  output logic [DW-1:0]            OUT_INSTR,
  input  logic                     FLUSH,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DepthCnt = (PW + 1)'(DEPTH);

  logic [AW-1:0] pc_mem_q    [DEPTH];
  logic [DW-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;

  logic push, pop;

  // Handshake status comes only from registered occupancy, never from the other side's inputs.
  assign FULL      = (count_q == DepthCnt);
  assign EMPTY     = (count_q == '0);
  assign IN_READY  = ~FULL;
  assign OUT_VALID = ~EMPTY;
  assign COUNT     = count_q;
  assign OUT_PC    = pc_mem_q[rd_ptr_q];
  assign OUT_INSTR = instr_mem_q[rd_ptr_q];

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero until the first push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push && !FLUSH) begin
      pc_mem_q[wr_ptr_q]    <= IN_PC;
      instr_mem_q[wr_ptr_q] <= IN_INSTR;
    end
  end

endmodule
